phase_sequencer: RTL and testbench

- Generates the five-phase timing (P1 fetch … P5 write-back) that drives the pipelined processor datapath.
- Outputs: current phase number, one-hot latch strobes (`phase_bus`) and one-hot bus-ownership windows (`fill_bus`).
- Adds run/stop, single-step and halt control.
- Sits directly upstream of the processor; its outputs connect 1:1 to the processor's `phase`/`phase_bus`/`fill_bus` consumers.

---
 rtl/seq_pkg.sv | 25 ++
 rtl/phase_sequencer_if.sv | 41 ++++
 rtl/sync_edge.sv | 29 ++
 rtl/phase_sequencer.sv | 135 +++++++++++++
 tb/tb_phase_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the five-phase sequencer: FSM states,
// phase indices and a one-hot helper used by the top and by consumers.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

  localparam int NUM_PHASES = 5;

  localparam logic [2:0] PH_P1 = 3'd0;
  localparam logic [2:0] PH_P2 = 3'd1;
  localparam logic [2:0] PH_P3 = 3'd2;
  localparam logic [2:0] PH_P4 = 3'd3;
  localparam logic [2:0] PH_P5 = 3'd4;

  // One-hot decode of a phase index (0..4) onto the five phase lines.
  function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [2:0] ph);
    phase_onehot = NUM_PHASES'(1) << ph;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/timing bundle between the phase sequencer and the processor.
// master = sequencer side (drives phase/strobe/fill), slave = consumer side
// (drives exec/step/halt). instr_count exists only with PHASE_SEQ_PERF_EN.
// There is no valid/ready handshake here: exec and step are level inputs
// that the sequencer synchronizes itself, halt is sampled on the last clock
// of P5, and every output is a registered level valid on every clock.
interface phase_sequencer_if;
  import seq_pkg::*;

  logic                  exec;
  logic                  step;
  logic                  halt;
  logic [2:0]            phase;
  logic [NUM_PHASES-1:0] phase_bus;
  logic [NUM_PHASES-1:0] fill_bus;
  logic                  running;
  logic                  halted;
  seq_state_t            state;      // debug view of the FSM
`ifdef PHASE_SEQ_PERF_EN
  logic [15:0]           instr_count;

  modport master (
    input  exec, step, halt,
    output phase, phase_bus, fill_bus, running, halted, state, instr_count
  );
  modport slave (
    output exec, step, halt,
    input  phase, phase_bus, fill_bus, running, halted, state, instr_count
  );
`else
  modport master (
    input  exec, step, halt,
    output phase, phase_bus, fill_bus, running, halted, state
  );
  modport slave (
    output exec, step, halt,
    input  phase, phase_bus, fill_bus, running, halted, state
  );
`endif

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level input followed by a
// registered rising-edge detector: one-clock pulse 3 clocks after the edge.
module sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q, pulse_q;

  // Synchronize, remember the previous synchronized level, register the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase (P1..P5) timing generator with run/stop, single-step and halt.
// All outputs are registered copies of next-state decode, so phase_bus is
// glitch-free and may be used as a clock by the datapath.
// Optional retired-instruction counter: define PHASE_SEQ_PERF_EN.
// PHASE_CYCLES must be even and >= 2; 1 <= STROBE_CYCLES < PHASE_CYCLES.
module phase_sequencer
  import seq_pkg::*;
#(
  parameter int PHASE_CYCLES  = 2,
  parameter int STROBE_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset,
  phase_sequencer_if.master  bus
);

  localparam int CCW = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CCW-1:0] CC_LAST = CCW'(PHASE_CYCLES - 1);
  localparam logic [CCW-1:0] CC_STB  = CCW'(PHASE_CYCLES - STROBE_CYCLES);

  logic                  exec_pulse, step_pulse;
  seq_state_t            state_q, state_d;
  logic [CCW-1:0]        cc_q, cc_d;
  logic [2:0]            ph_q, ph_d;
  logic                  stop_pend_q, stop_pend_d;
  logic [NUM_PHASES-1:0] fill_q, fill_d;
  logic [NUM_PHASES-1:0] pb_q, pb_d;
  logic                  running_q, running_d;
  logic                  halted_q, halted_d;
  logic                  last_clk, retire;

  sync_edge u_exec_sync (.clock(clock), .reset(reset), .d_i(bus.exec), .pulse_o(exec_pulse));
  sync_edge u_step_sync (.clock(clock), .reset(reset), .d_i(bus.step), .pulse_o(step_pulse));

  // Next-state, phase counter and output decode; outputs derive from the
  // next state so their registers line up with the state registers.
  always_comb begin
    state_d     = state_q;
    cc_d        = cc_q;
    ph_d        = ph_q;
    stop_pend_d = stop_pend_q;
    last_clk    = (cc_q == CC_LAST) && (ph_q == PH_P5);
    retire      = 1'b0;

    case (state_q)
      IDLE: begin
        cc_d = '0;
        ph_d = PH_P1;
        if (exec_pulse)      state_d = RUN;
        else if (step_pulse) state_d = STEP;
      end
      RUN, STEP: begin
        if (state_q == RUN && exec_pulse) stop_pend_d = 1'b1;
        if (cc_q == CC_LAST) begin
          cc_d = '0;
          ph_d = (ph_q == PH_P5) ? PH_P1 : ph_q + 3'd1;
        end else begin
          cc_d = cc_q + CCW'(1);
        end
        // Exits only at the end of P5, so an instruction is never cut short.
        if (last_clk) begin
          retire = 1'b1;
          if (bus.halt) begin
            state_d     = HALTED;
            stop_pend_d = 1'b0;
          end else if (state_q == STEP || stop_pend_q) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end
        end
      end
      HALTED: begin
        cc_d = '0;
        ph_d = PH_P1;
      end
      default: begin
        state_d     = IDLE;
        cc_d        = '0;
        ph_d        = PH_P1;
        stop_pend_d = 1'b0;
      end
    endcase

    running_d = (state_d == RUN) || (state_d == STEP);
    halted_d  = (state_d == HALTED);
    fill_d    = running_d ? phase_onehot(ph_d) : '0;
    pb_d      = (running_d && (cc_d >= CC_STB)) ? phase_onehot(ph_d) : '0;
  end

  // State, phase counter and registered outputs; reset drops everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cc_q        <= '0;
      ph_q        <= PH_P1;
      stop_pend_q <= 1'b0;
      fill_q      <= '0;
      pb_q        <= '0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cc_q        <= cc_d;
      ph_q        <= ph_d;
      stop_pend_q <= stop_pend_d;
      fill_q      <= fill_d;
      pb_q        <= pb_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.phase     = ph_q;
  assign bus.phase_bus = pb_q;
  assign bus.fill_bus  = fill_q;
  assign bus.running   = running_q;
  assign bus.halted    = halted_q;
  assign bus.state     = state_q;

`ifdef PHASE_SEQ_PERF_EN
  logic [15:0] count_q;

  // Count every completed P5 in RUN or STEP, the halting one included.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       count_q <= '0;
    else if (retire) count_q <= count_q + 16'd1;
  end

  assign bus.instr_count = count_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a default-parameter instance (dut)
// and a PHASE_CYCLES=4 / STROBE_CYCLES=2 instance (dut4) on one clock.
module tb_phase_sequencer;
  import seq_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  phase_sequencer_if bus1 ();
  phase_sequencer_if bus2 ();

  phase_sequencer #(.PHASE_CYCLES(2), .STROBE_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .bus(bus1)
  );
  phase_sequencer #(.PHASE_CYCLES(4), .STROBE_CYCLES(2)) dut4 (
    .clock(clock), .reset(reset), .bus(bus2)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Raise exec for two clocks then drop it; pulse lands inside the DUT later.
  task automatic press_exec();
    bus1.exec = 1'b1;
    ticks(2);
    bus1.exec = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && bus1.running; i++) tick();
    check(name, bus1.running, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       exec;
    logic       step;
    logic [2:0] ph;
    logic [4:0] pb;
    logic [4:0] fill;
    logic       run;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic e, input logic s, input logic [2:0] ph,
                              input logic [4:0] pb, input logic [4:0] fill, input logic run);
    vec_t v;
    v.exec = e; v.step = s; v.ph = ph; v.pb = pb; v.fill = fill; v.run = run;
    return v;
  endfunction

  // ---------------- scoreboard for the 4/2 instance ----------------
  logic [9:0] exp_q[$];

  initial begin
    logic [9:0] exp_v;
    logic [4:0] prev_fill, prev_pb, rising;

    bus1.exec = 1'b0; bus1.step = 1'b0; bus1.halt = 1'b0;
    bus2.exec = 1'b0; bus2.step = 1'b0; bus2.halt = 1'b0;

    // exec start, run two instructions, exec during P2 stops, exec restarts
    vecs[0]  = mk(1, 0, 3'd0, 5'b00000, 5'b00000, 0);
    vecs[1]  = mk(1, 0, 3'd0, 5'b00000, 5'b00000, 0);
    vecs[2]  = mk(0, 0, 3'd0, 5'b00000, 5'b00000, 0);
    vecs[3]  = mk(0, 0, 3'd0, 5'b00000, 5'b00001, 1);
    vecs[4]  = mk(0, 0, 3'd0, 5'b00001, 5'b00001, 1);
    vecs[5]  = mk(0, 0, 3'd1, 5'b00000, 5'b00010, 1);
    vecs[6]  = mk(0, 0, 3'd1, 5'b00010, 5'b00010, 1);
    vecs[7]  = mk(0, 0, 3'd2, 5'b00000, 5'b00100, 1);
    vecs[8]  = mk(0, 0, 3'd2, 5'b00100, 5'b00100, 1);
    vecs[9]  = mk(0, 0, 3'd3, 5'b00000, 5'b01000, 1);
    vecs[10] = mk(0, 0, 3'd3, 5'b01000, 5'b01000, 1);
    vecs[11] = mk(0, 0, 3'd4, 5'b00000, 5'b10000, 1);
    vecs[12] = mk(0, 0, 3'd4, 5'b10000, 5'b10000, 1);
    vecs[13] = mk(0, 0, 3'd0, 5'b00000, 5'b00001, 1);
    vecs[14] = mk(0, 0, 3'd0, 5'b00001, 5'b00001, 1);
    vecs[15] = mk(1, 0, 3'd1, 5'b00000, 5'b00010, 1);
    vecs[16] = mk(1, 0, 3'd1, 5'b00010, 5'b00010, 1);
    vecs[17] = mk(0, 0, 3'd2, 5'b00000, 5'b00100, 1);
    vecs[18] = mk(0, 0, 3'd2, 5'b00100, 5'b00100, 1);
    vecs[19] = mk(0, 0, 3'd3, 5'b00000, 5'b01000, 1);
    vecs[20] = mk(0, 0, 3'd3, 5'b01000, 5'b01000, 1);
    vecs[21] = mk(0, 0, 3'd4, 5'b00000, 5'b10000, 1);
    vecs[22] = mk(0, 0, 3'd4, 5'b10000, 5'b10000, 1);
    vecs[23] = mk(0, 0, 3'd0, 5'b00000, 5'b00000, 0);
    vecs[24] = mk(0, 0, 3'd0, 5'b00000, 5'b00000, 0);
    vecs[25] = mk(1, 0, 3'd0, 5'b00000, 5'b00000, 0);
    vecs[26] = mk(1, 0, 3'd0, 5'b00000, 5'b00000, 0);
    vecs[27] = mk(0, 0, 3'd0, 5'b00000, 5'b00000, 0);
    vecs[28] = mk(0, 0, 3'd0, 5'b00000, 5'b00001, 1);
    vecs[29] = mk(0, 0, 3'd0, 5'b00001, 5'b00001, 1);

    // ---- reset state ----
    ticks(2);
    check("rst_phase",   bus1.phase,     3'd0);
    check("rst_pb",      bus1.phase_bus, 5'b0);
    check("rst_fill",    bus1.fill_bus,  5'b0);
    check("rst_running", bus1.running,   1'b0);
    check("rst_halted",  bus1.halted,    1'b0);
    check("rst_state",   bus1.state,     IDLE);
`ifdef PHASE_SEQ_PERF_EN
    check("rst_count",   bus1.instr_count, 16'd0);
`endif
    reset = 1'b0;
    ticks(2);

    // ---- table-driven run / stop / restart ----
    for (int i = 0; i < 30; i++) begin
      bus1.exec = vecs[i].exec;
      bus1.step = vecs[i].step;
      tick();
      check($sformatf("vec%0d_phase", i),   bus1.phase,     vecs[i].ph);
      check($sformatf("vec%0d_pb", i),      bus1.phase_bus, vecs[i].pb);
      check($sformatf("vec%0d_fill", i),    bus1.fill_bus,  vecs[i].fill);
      check($sformatf("vec%0d_running", i), bus1.running,   vecs[i].run);
    end
    press_exec();
    wait_idle("stop_after_restart", 40);
    check("stop_state", bus1.state, IDLE);
    check("stop_fill",  bus1.fill_bus, 5'b0);

    // ---- single step: one P1..P5 pass, step during STEP ignored ----
    do_reset();
    bus1.step = 1'b1;
    ticks(2);
    bus1.step = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("step%0d_running", k), bus1.running, 1'b1);
      check($sformatf("step%0d_fill", k), bus1.fill_bus, 5'b00001 << (k / 2));
      check($sformatf("step%0d_pb", k), bus1.phase_bus,
            (k % 2 == 1) ? (5'b00001 << (k / 2)) : 5'b00000);
      if (k == 2) bus1.step = 1'b1;
      if (k == 4) bus1.step = 1'b0;
    end
    tick();
    check("step_end_running", bus1.running,  1'b0);
    check("step_end_fill",    bus1.fill_bus, 5'b0);
    check("step_end_phase",   bus1.phase,    3'd0);
    check("step_end_state",   bus1.state,    IDLE);
    ticks(6);
    check("step_stays_idle",  bus1.state,    IDLE);
`ifdef PHASE_SEQ_PERF_EN
    check("step_count", bus1.instr_count, 16'd1);
`endif

    // ---- halt on the last clock of P5 ----
    press_exec();
    for (int i = 0; i < 30 && !(bus1.phase == 3'd4 && bus1.phase_bus[4]); i++) tick();
    check("halt_reach_p5_strobe", bus1.phase_bus, 5'b10000);
    bus1.halt = 1'b1;
    tick();
    bus1.halt = 1'b0;
    check("halt_halted",  bus1.halted,    1'b1);
    check("halt_running", bus1.running,   1'b0);
    check("halt_fill",    bus1.fill_bus,  5'b0);
    check("halt_pb",      bus1.phase_bus, 5'b0);
    check("halt_phase",   bus1.phase,     3'd0);
    check("halt_state",   bus1.state,     HALTED);
`ifdef PHASE_SEQ_PERF_EN
    check("halt_count",   bus1.instr_count, 16'd2);
`endif
    bus1.exec = 1'b1;
    bus1.step = 1'b1;
    ticks(3);
    bus1.exec = 1'b0;
    bus1.step = 1'b0;
    ticks(6);
    check("halt_sticky_state", bus1.state,    HALTED);
    check("halt_sticky_fill",  bus1.fill_bus, 5'b0);
    check("halt_sticky_halted", bus1.halted,  1'b1);

    // ---- asynchronous reset mid-P3 ----
    do_reset();
    press_exec();
    for (int i = 0; i < 20 && bus1.phase != 3'd2; i++) tick();
    check("arst_reach_p3", bus1.fill_bus, 5'b00100);
    reset = 1'b1;
    #1;
    check("arst_phase",   bus1.phase,     3'd0);
    check("arst_fill",    bus1.fill_bus,  5'b0);
    check("arst_pb",      bus1.phase_bus, 5'b0);
    check("arst_running", bus1.running,   1'b0);
    check("arst_state",   bus1.state,     IDLE);
    tick();
    reset = 1'b0;
    ticks(3);
    check("arst_after_state", bus1.state,     IDLE);
    check("arst_after_pb",    bus1.phase_bus, 5'b0);
    check("arst_after_fill",  bus1.fill_bus,  5'b0);

    // ---- exec and step on the same clock: exec wins ----
    bus1.exec = 1'b1;
    bus1.step = 1'b1;
    ticks(2);
    bus1.exec = 1'b0;
    bus1.step = 1'b0;
    for (int i = 0; i < 10 && !bus1.running; i++) tick();
    check("both_state", bus1.state, RUN);
    ticks(12);
    check("both_still_running", bus1.running, 1'b1);
    press_exec();
    wait_idle("both_stop", 40);

    // ---- PHASE_CYCLES=4, STROBE_CYCLES=2 instance ----
    for (int p = 0; p < NUM_PHASES; p++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back({(c >= 2) ? (5'b00001 << p) : 5'b00000, 5'b00001 << p});
    bus2.exec = 1'b1;
    ticks(2);
    bus2.exec = 1'b0;
    for (int i = 0; i < 10 && bus2.fill_bus == 5'b0; i++) tick();
    check("p4_started", bus2.fill_bus, 5'b00001);
    prev_fill = 5'b0;
    prev_pb   = 5'b0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check("p4_pb_fill", {bus2.phase_bus, bus2.fill_bus}, exp_v);
      rising = bus2.phase_bus & ~prev_pb;
      if (rising != 5'b0) check("p4_edge_in_fill", rising & prev_fill, rising);
      prev_fill = bus2.fill_bus;
      prev_pb   = bus2.phase_bus;
      tick();
    end
    check("p4_wrap_fill", bus2.fill_bus, 5'b00001);
    bus2.exec = 1'b1;
    ticks(2);
    bus2.exec = 1'b0;
    for (int i = 0; i < 60 && bus2.running; i++) tick();
    check("p4_stop", bus2.running, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
